softmax_argmax: RTL and testbench

Classification stage placed directly after the 10-way softmax. It captures the ten IEEE-754 single-precision probabilities when the softmax acknowledge asserts, then scans them one element per clock. It reports the index of the largest value and that value, and raises its own acknowledge. Its outputs are the final class decision of the CNN.

---
 rtl/softmax_argmax_pkg.sv | 28 ++
 rtl/softmax_argmax_if.sv | 22 ++
 rtl/softmax_argmax_float_greater.sv | 43 ++++
 rtl/softmax_argmax.sv | 115 +++++++++++
 tb/tb_softmax_argmax.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/softmax_argmax_pkg.sv
// Shared definitions for the softmax classification stage: default sizes,
// IEEE-754 single-precision field positions and the scan FSM encoding.
package softmax_argmax_pkg;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_INPUT_NUM  = 10;
  localparam int IDX_W          = 4;

  localparam int SIGN_BIT = 31;
  localparam int EXP_MSB  = 30;
  localparam int EXP_LSB  = 23;
  localparam int MAN_MSB  = 22;
  localparam int MAN_LSB  = 0;

  localparam logic [7:0] EXP_ALL_ONES = 8'hFF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // A float is NaN when its exponent is all ones and its mantissa is non-zero.
  function automatic logic is_nan(input logic [31:0] f);
    return (f[EXP_MSB:EXP_LSB] == EXP_ALL_ONES) && (f[MAN_MSB:MAN_LSB] != '0);
  endfunction

endpackage

// File: rtl/softmax_argmax_if.sv
// Bus between the softmax stage and the classification stage: the ten
// probabilities with their start level, and the class decision with its ack.
interface softmax_argmax_if #(
  parameter int DATA_WIDTH = 32,
  parameter int INPUT_NUM  = 10
);
  logic [DATA_WIDTH*INPUT_NUM-1:0] inputs;
  logic                            enable;
  logic [3:0]                      class_idx;
  logic [DATA_WIDTH-1:0]           class_prob;
  logic                            ack;

  modport master (
    output inputs, enable,
    input  class_idx, class_prob, ack
  );

  modport slave (
    input  inputs, enable,
    output class_idx, class_prob, ack
  );
endinterface

// File: rtl/softmax_argmax_float_greater.sv
// Combinational "a strictly greater than b" for single-precision floats.
// Signed zeros are equal, a NaN a is never greater, and any non-NaN a beats a
// NaN b so a NaN seed value is displaced by the first real number.
module float_greater
  import softmax_argmax_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        gt
);

  logic        w_a_nan;
  logic        w_b_nan;
  logic [30:0] w_a_mag;
  logic [30:0] w_b_mag;
  logic        w_both_zero;

  assign w_a_nan     = is_nan(a);
  assign w_b_nan     = is_nan(b);
  assign w_a_mag     = a[EXP_MSB:MAN_LSB];
  assign w_b_mag     = b[EXP_MSB:MAN_LSB];
  assign w_both_zero = (w_a_mag == '0) && (w_b_mag == '0);

  // Sign-magnitude ordering with NaN and signed-zero special cases first.
  always_comb begin
    gt = 1'b0;
    if (w_a_nan) begin
      gt = 1'b0;
    end else if (w_b_nan) begin
      gt = 1'b1;
    end else if (w_both_zero) begin
      gt = 1'b0;
    end else begin
      case ({a[SIGN_BIT], b[SIGN_BIT]})
        2'b00:   gt = (w_a_mag > w_b_mag);
        2'b01:   gt = 1'b1;
        2'b10:   gt = 1'b0;
        default: gt = (w_a_mag < w_b_mag);
      endcase
    end
  end

endmodule

// File: rtl/softmax_argmax.sv
// Final CNN classification: captures the ten softmax probabilities on enable,
// scans them one per clock for the largest value (lowest index on ties) and
// holds the index/value with ack until enable drops.
module softmax_argmax
  import softmax_argmax_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int INPUT_NUM  = DEF_INPUT_NUM
) (
  input  logic             clk,
  input  logic             reset,
  softmax_argmax_if.slave  bus
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(INPUT_NUM - 1);

  state_t                r_state;
  state_t                w_state_nxt;

  logic [DATA_WIDTH-1:0] r_buf [INPUT_NUM];
  logic [IDX_W-1:0]      r_cnt;
  logic [DATA_WIDTH-1:0] r_best_val;
  logic [IDX_W-1:0]      r_best_idx;
  logic [IDX_W-1:0]      r_class_idx;
  logic [DATA_WIDTH-1:0] r_class_prob;
  logic                  r_ack;

  logic [DATA_WIDTH-1:0] w_elem;
  logic                  w_gt;
  logic                  w_last;
  logic [DATA_WIDTH-1:0] w_best_val_nxt;
  logic [IDX_W-1:0]      w_best_idx_nxt;

  assign w_elem         = r_buf[r_cnt];
  assign w_last         = (r_cnt == LAST_IDX);
  assign w_best_val_nxt = w_gt ? w_elem : r_best_val;
  assign w_best_idx_nxt = w_gt ? r_cnt  : r_best_idx;

  float_greater u_float_greater (
    .a  (w_elem),
    .b  (r_best_val),
    .gt (w_gt)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state: capture on enable, scan to the last element, hold until enable drops.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (bus.enable)  w_state_nxt = ST_SCAN;
      ST_SCAN: if (w_last)      w_state_nxt = ST_DONE;
      ST_DONE: if (!bus.enable) w_state_nxt = ST_IDLE;
      default:                  w_state_nxt = ST_IDLE;
    endcase
  end

  // Datapath: buffer capture, running best, result load and ack.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < INPUT_NUM; k++) begin
        r_buf[k] <= '0;
      end
      r_cnt        <= '0;
      r_best_val   <= '0;
      r_best_idx   <= '0;
      r_class_idx  <= '0;
      r_class_prob <= '0;
      r_ack        <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.enable) begin
            for (int k = 0; k < INPUT_NUM; k++) begin
              r_buf[k] <= bus.inputs[DATA_WIDTH*k +: DATA_WIDTH];
            end
            r_best_val <= bus.inputs[DATA_WIDTH-1:0];
            r_best_idx <= '0;
            r_cnt      <= IDX_W'(1);
          end
        end
        ST_SCAN: begin
          r_best_val <= w_best_val_nxt;
          r_best_idx <= w_best_idx_nxt;
          r_cnt      <= r_cnt + IDX_W'(1);
          if (w_last) begin
            r_class_idx  <= w_best_idx_nxt;
            r_class_prob <= w_best_val_nxt;
            r_ack        <= 1'b1;
          end
        end
        ST_DONE: begin
          if (!bus.enable) begin
            r_ack <= 1'b0;
          end
        end
        default: begin
          r_ack <= 1'b0;
        end
      endcase
    end
  end

  assign bus.class_idx  = r_class_idx;
  assign bus.class_prob = r_class_prob;
  assign bus.ack        = r_ack;

endmodule

// File: tb/tb_softmax_argmax.sv
// Bench for softmax_argmax: directed cases, randomized vectors against an
// integer-key reference model, reset mid-scan and single-cycle enable pulse.
module tb_softmax_argmax;

  typedef logic [31:0] vec_t [10];

  logic clk;
  logic reset;
  int   n_chk;
  int   n_pass;

  softmax_argmax_if #(.DATA_WIDTH(32), .INPUT_NUM(10)) bus ();

  softmax_argmax #(.DATA_WIDTH(32), .INPUT_NUM(10)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: map each non-NaN float to a signed integer key (-0 and +0 both 0),
  // take the first index of the largest key; all-NaN leaves element 0.
  function automatic void model(input vec_t v, output logic [3:0] idx, output logic [31:0] val);
    int     best;
    longint bk;
    longint key;
    best = -1;
    bk   = 0;
    for (int i = 0; i < 10; i++) begin
      if (v[i][30:23] == 8'hFF && v[i][22:0] != 23'd0) continue;
      key = v[i][31] ? -longint'(v[i][30:0]) : longint'(v[i][30:0]);
      if (best < 0 || key > bk) begin
        best = i;
        bk   = key;
      end
    end
    if (best < 0) best = 0;
    idx = 4'(best);
    val = v[best];
  endfunction

  task automatic drive_inputs(input vec_t v);
    for (int k = 0; k < 10; k++) bus.inputs[32*k +: 32] = v[k];
  endtask

  task automatic fill(output vec_t v, input logic [31:0] dflt);
    for (int k = 0; k < 10; k++) v[k] = dflt;
  endtask

  // Full transaction with enable held through DONE, then released.
  task automatic run_case(input vec_t v, input string name);
    logic [3:0]  e_idx;
    logic [31:0] e_val;
    int          n;
    model(v, e_idx, e_val);
    @(negedge clk);
    drive_inputs(v);
    bus.enable = 1'b1;
    n = 0;
    while (n < 20) begin
      @(negedge clk);
      n++;
      if (bus.ack === 1'b1) break;
    end
    n_chk++;
    if (n !== 10) $display("FAIL %s latency: got %0d cycles, expected 10", name, n);
    else n_pass++;
    n_chk++;
    if (bus.class_idx !== e_idx) $display("FAIL %s idx: got %0d, expected %0d", name, bus.class_idx, e_idx);
    else n_pass++;
    n_chk++;
    if (bus.class_prob !== e_val) $display("FAIL %s prob: got %h, expected %h", name, bus.class_prob, e_val);
    else n_pass++;
    @(negedge clk);
    n_chk++;
    if (bus.ack !== 1'b1 || bus.class_idx !== e_idx) $display("FAIL %s hold: ack=%b idx=%0d, expected ack=1 idx=%0d", name, bus.ack, bus.class_idx, e_idx);
    else n_pass++;
    bus.enable = 1'b0;
    @(negedge clk);
    n_chk++;
    if (bus.ack !== 1'b0 || bus.class_idx !== e_idx || bus.class_prob !== e_val)
      $display("FAIL %s release: ack=%b idx=%0d prob=%h, expected ack=0 idx=%0d prob=%h", name, bus.ack, bus.class_idx, bus.class_prob, e_idx, e_val);
    else n_pass++;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.enable = 1'b0;
    bus.inputs = '0;
    repeat (3) @(negedge clk);
    n_chk++;
    if (bus.ack !== 1'b0) $display("FAIL reset_ack: got %b, expected 0", bus.ack);
    else n_pass++;
    n_chk++;
    if (bus.class_idx !== 4'd0) $display("FAIL reset_idx: got %0d, expected 0", bus.class_idx);
    else n_pass++;
    n_chk++;
    if (bus.class_prob !== 32'h0) $display("FAIL reset_prob: got %h, expected 0", bus.class_prob);
    else n_pass++;
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_directed();
    vec_t v;
    fill(v, 32'h3DCCCCCD); v[7] = 32'h3F000000;
    run_case(v, "single_max");
    fill(v, 32'h3E800000); v[2] = 32'h3F800000; v[5] = 32'h3F800000;
    run_case(v, "tie_lowest");
    fill(v, 32'h00000000); v[0] = 32'h7FC00000; v[4] = 32'h3E800000;
    run_case(v, "nan_first");
    fill(v, 32'hC0000000); v[1] = 32'hBF800000; v[3] = 32'h80000000;
    run_case(v, "mixed_sign");
    fill(v, 32'h7FC00001);
    run_case(v, "all_nan");
    fill(v, 32'h3F800000); v[6] = 32'h7F800000; v[8] = 32'h7F800001;
    run_case(v, "inf_vs_nan");
  endtask

  task automatic test_random();
    vec_t v;
    int   kind;
    for (int t = 0; t < 20; t++) begin
      for (int k = 0; k < 10; k++) begin
        kind = $urandom_range(0, 9);
        case (kind)
          0: v[k] = {1'($urandom), 8'hFF, 23'($urandom_range(1, 32'h7FFFFF))};
          1: v[k] = {1'($urandom), 31'd0};
          2: v[k] = {1'($urandom), 8'hFF, 23'd0};
          3: v[k] = (k > 0) ? v[$urandom_range(0, k - 1)] : 32'h3F000000;
          default: v[k] = {1'($urandom), 8'($urandom_range(0, 254)), 23'($urandom)};
        endcase
      end
      run_case(v, $sformatf("random_%0d", t));
    end
  endtask

  task automatic test_reset_mid_scan();
    vec_t v;
    vec_t w;
    int   seen;
    fill(v, 32'h3E000000); v[9] = 32'h3F400000;
    fill(w, 32'h40000000);
    @(negedge clk);
    drive_inputs(v);
    bus.enable = 1'b1;
    repeat (3) @(negedge clk);
    drive_inputs(w);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    bus.enable = 1'b0;
    @(negedge clk);
    n_chk++;
    if (bus.ack !== 1'b0 || bus.class_idx !== 4'd0 || bus.class_prob !== 32'h0)
      $display("FAIL midreset_clear: ack=%b idx=%0d prob=%h, expected all zero", bus.ack, bus.class_idx, bus.class_prob);
    else n_pass++;
    reset = 1'b0;
    seen = 0;
    repeat (15) begin
      @(negedge clk);
      if (bus.ack !== 1'b0) seen++;
    end
    n_chk++;
    if (seen !== 0) $display("FAIL midreset_noack: ack high %0d cycles, expected 0", seen);
    else n_pass++;
    run_case(v, "after_reset");
  endtask

  task automatic test_pulse();
    vec_t v;
    int   n;
    fill(v, 32'h3DCCCCCD); v[0] = 32'h3F600000; v[5] = 32'h3F600000;
    @(negedge clk);
    drive_inputs(v);
    bus.enable = 1'b1;
    @(negedge clk);
    bus.enable = 1'b0;
    bus.inputs = '0;
    n = 1;
    while (n < 20 && bus.ack !== 1'b1) begin
      @(negedge clk);
      n++;
    end
    n_chk++;
    if (n !== 10) $display("FAIL pulse_latency: got %0d cycles, expected 10", n);
    else n_pass++;
    n_chk++;
    if (bus.class_idx !== 4'd0 || bus.class_prob !== 32'h3F600000)
      $display("FAIL pulse_result: idx=%0d prob=%h, expected idx=0 prob=3f600000", bus.class_idx, bus.class_prob);
    else n_pass++;
    @(negedge clk);
    n_chk++;
    if (bus.ack !== 1'b0) $display("FAIL pulse_width: ack=%b one cycle later, expected 0", bus.ack);
    else n_pass++;
    n_chk++;
    if (bus.class_idx !== 4'd0 || bus.class_prob !== 32'h3F600000)
      $display("FAIL pulse_retain: idx=%0d prob=%h, expected idx=0 prob=3f600000", bus.class_idx, bus.class_prob);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    vec_t v;
    fill(v, 32'hBF000000); v[4] = 32'hBE000000;
    run_case(v, "b2b_first");
    fill(v, 32'h41200000); v[9] = 32'h41300000;
    run_case(v, "b2b_second");
  endtask

  initial begin
    n_chk  = 0;
    n_pass = 0;
    reset  = 1'b1;
    bus.enable = 1'b0;
    bus.inputs = '0;
    test_reset();
    test_directed();
    test_random();
    test_reset_mid_scan();
    test_back_to_back();
    test_pulse();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
